core_decode_stage: RTL and testbench
====================================

Name: core_decode_stage

Overview:
Pipeline decode stage of the LETC core.
- Accepts raw 32-bit instruction words and their PC from fetch through a valid/ready handshake.
- Classifies each word using the core_pkg opcode/format/source enums and extracts register indices and the sign-extended immediate.
- Presents a registered decoded bundle to execute through a second valid/ready handshake.
- Contains a 2-entry skid buffer so that both ready signals are register outputs.

Parameters:
- PC_WIDTH, 32, width of pc input/output.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_flush  in  1  discard all buffered and in-flight entries
- i_if_valid  in  1  fetch has an instruction
- o_if_ready  out  1  stage can accept this cycle
- i_if_instr  in  32  instruction word
- i_if_pc  in  PC_WIDTH  instruction address
- o_ex_valid  out  1  decoded bundle valid
- i_ex_ready  in  1  execute accepts bundle
- o_ex_pc  out  PC_WIDTH  PC of bundle
- o_ex_rd_idx, o_ex_rs1_idx, o_ex_rs2_idx  out  5 each  reg_idx_t fields
- o_ex_imm  out  32  sign-extended immediate
- o_ex_format  out  3  instr_format_e
- o_ex_rd_src  out  2  rd_src_e
- o_ex_op1_src  out  2  alu_op1_src_e
- o_ex_op2_src  out  2  alu_op2_src_e
- o_ex_cmp_op  out  3  cmp_op_e (funct3 pass-through for BRANCH)
- o_ex_rd_we  out  1  writes rd (forced 0 when rd_idx==0)
- o_ex_illegal  out  1  illegal/unsupported encoding

Behaviour:
- Reset (clk edge with rst=1):
  - o_ex_valid=0, o_if_ready=1, skid buffer empty.
  - All o_ex_* data outputs reset to 0 (format=INSTR_FORMAT_R).
- Handshakes:
  - A transfer occurs when valid&&ready on the same edge.
  - Upstream fetch must hold instr/pc stable while i_if_valid=1 and o_if_ready=0.
  - Outputs hold stable while o_ex_valid=1 and i_ex_ready=0.
- Latency: an instruction accepted at edge N is presented at edge N+1 when the output register is empty or draining.
- Throughput: 1 instruction/cycle sustained while i_ex_ready=1.
- Skid buffer:
  - States EMPTY, ONE (output reg full), TWO (output reg + skid reg full).
  - EMPTY -> ONE on accept.
  - ONE -> ONE on accept with drain; ONE -> TWO on accept without drain; ONE -> EMPTY on drain without accept.
  - TWO -> ONE on drain: the skid entry moves to the output register; no accept is possible in TWO.
  - o_if_ready = (state != TWO), registered.
- Decode:
  - Performed combinationally on the input path and registered into the output or skid register.
  - Opcode = instr[6:2]; instr[1:0] != 2'b11 -> illegal.
- Formats and immediates:
  - LUI, AUIPC: U; imm = {instr[31:12],12'b0}.
  - JAL: J; JALR, LOAD, OP_IMM, MISC_MEM: I.
  - STORE: S. BRANCH: B. OP: R.
  - SYSTEM with funct3 in {101,110,111}: UIMM, imm = zero-extended instr[19:15]; other SYSTEM: I.
  - Any other opcode: OTHER with illegal=1.
  - I/S/B/J immediates are sign-extended per RV32I bit scrambling; B and J immediates have LSB 0.
- Register write and rd source:
  - rd_we = 0 for STORE, BRANCH, MISC_MEM and illegal encodings, and whenever rd_idx==0.
  - rd_src: JAL/JALR -> NEXT_SEQ_PC, LOAD -> MEM_LOAD, SYSTEM CSR ops -> CSR, otherwise ALU_RESULT.
- ALU operand sources:
  - op1_src = PC for AUIPC/JAL/BRANCH, CSR_UIMM for UIMM format, otherwise RS1.
  - op2_src = RS2 for R/B formats, IMM otherwise.
- cmp_op: BRANCH funct3 in {010,011} -> illegal.
- Flush:
  - i_flush=1 at an edge empties both registers (state EMPTY, o_ex_valid=0) and drops any simultaneous input transfer.
  - Flush takes priority over accept and drain.
  - rst takes priority over flush.
- Reset mid-transfer: any in-flight entry is lost; no partial outputs.

Decomposition:
- Into core_pkg:
  - decoded-bundle struct decode_out_s (all o_ex_* data fields).
  - funct3 constants for SYSTEM CSR variants.
  - skid state enum decode_skid_state_e.
- Sub-module core_decode_comb: purely combinational instr -> decode_out_s; the stage instantiates it once on the input path.

Test Plan:
- Reset, then one ADDI x5,x1,-1 (0xFFF08293) at pc 0x100, i_ex_ready=1 -> next cycle o_ex_valid=1, format I, imm 0xFFFFFFFF, rd_idx 5, rs1 1, rd_we 1, op2_src IMM, rd_src ALU_RESULT.
- Backpressure: stream BEQ x0,x0,-4 (0xFE000EE3) then LUI x1,0x12345 (0x123450B7) with i_ex_ready=0 -> o_if_ready falls after 2 accepts; outputs hold BEQ (imm 0xFFFFFFFC, op1 PC, cmp EQ). Release ready -> LUI (imm 0x12345000) follows next cycle, no loss or duplication.
- Full throughput: 8 back-to-back instructions with i_ex_ready=1 -> 8 bundles on 8 consecutive cycles in order.
- Flush while in TWO -> next cycle o_ex_valid=0, o_if_ready=1; an input offered in the flush cycle is not output.
- Illegal words 0x00000000 and 0x0000007F -> o_ex_illegal=1, rd_we=0, format OTHER. CSRRWI x3,mstatus,5 (0x3002D1F3) -> UIMM, imm 5, rd_src CSR.
- ADD x0,x1,x2 (0x00208033) -> rd_we=0. Assert rst mid-stream -> o_ex_valid=0 at next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the LETC core: opcode map, decode field enums,
// the decoded-bundle struct and the decode skid-buffer state.
package core_pkg;

  typedef logic [4:0] reg_idx_t;

  // Major opcode, instr[6:2] (instr[1:0] must be 2'b11)
  typedef enum logic [4:0] {
    OPCODE_LOAD     = 5'b00000,
    OPCODE_MISC_MEM = 5'b00011,
    OPCODE_OP_IMM   = 5'b00100,
    OPCODE_AUIPC    = 5'b00101,
    OPCODE_STORE    = 5'b01000,
    OPCODE_OP       = 5'b01100,
    OPCODE_LUI      = 5'b01101,
    OPCODE_BRANCH   = 5'b11000,
    OPCODE_JALR     = 5'b11001,
    OPCODE_JAL      = 5'b11011,
    OPCODE_SYSTEM   = 5'b11100
  } opcode_e;

  typedef enum logic [2:0] {
    INSTR_FORMAT_R     = 3'd0,
    INSTR_FORMAT_I     = 3'd1,
    INSTR_FORMAT_S     = 3'd2,
    INSTR_FORMAT_B     = 3'd3,
    INSTR_FORMAT_U     = 3'd4,
    INSTR_FORMAT_J     = 3'd5,
    INSTR_FORMAT_UIMM  = 3'd6,
    INSTR_FORMAT_OTHER = 3'd7
  } instr_format_e;

  typedef enum logic [1:0] {
    RD_SRC_ALU_RESULT  = 2'd0,
    RD_SRC_MEM_LOAD    = 2'd1,
    RD_SRC_CSR         = 2'd2,
    RD_SRC_NEXT_SEQ_PC = 2'd3
  } rd_src_e;

  typedef enum logic [1:0] {
    ALU_OP1_SRC_RS1      = 2'd0,
    ALU_OP1_SRC_PC       = 2'd1,
    ALU_OP1_SRC_CSR_UIMM = 2'd2
  } alu_op1_src_e;

  typedef enum logic [1:0] {
    ALU_OP2_SRC_RS2 = 2'd0,
    ALU_OP2_SRC_IMM = 2'd1
  } alu_op2_src_e;

  // Branch comparison, encoded as the BRANCH funct3 itself
  typedef enum logic [2:0] {
    CMP_OP_EQ  = 3'b000,
    CMP_OP_NE  = 3'b001,
    CMP_OP_LT  = 3'b100,
    CMP_OP_GE  = 3'b101,
    CMP_OP_LTU = 3'b110,
    CMP_OP_GEU = 3'b111
  } cmp_op_e;

  // SYSTEM funct3 values for the CSR instructions
  localparam logic [2:0] FUNCT3_ECALL_EBREAK = 3'b000;
  localparam logic [2:0] FUNCT3_CSRRW        = 3'b001;
  localparam logic [2:0] FUNCT3_CSRRS        = 3'b010;
  localparam logic [2:0] FUNCT3_CSRRC        = 3'b011;
  localparam logic [2:0] FUNCT3_CSRRWI       = 3'b101;
  localparam logic [2:0] FUNCT3_CSRRSI       = 3'b110;
  localparam logic [2:0] FUNCT3_CSRRCI       = 3'b111;

  typedef struct packed {
    reg_idx_t      rd_idx;
    reg_idx_t      rs1_idx;
    reg_idx_t      rs2_idx;
    logic [31:0]   imm;
    instr_format_e format;
    rd_src_e       rd_src;
    alu_op1_src_e  op1_src;
    alu_op2_src_e  op2_src;
    cmp_op_e       cmp_op;
    logic          rd_we;
    logic          illegal;
  } decode_out_s;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } decode_skid_state_e;

endpackage

// File: rtl/core_decode_comb.sv
// Purely combinational RV32I instruction classifier: raw word in,
// decoded bundle (indices, immediate, operand/result routing) out.
module core_decode_comb
  import core_pkg::*;
(
  input  logic [31:0] i_instr,
  output decode_out_s o_dec
);

  logic [2:0]    w_funct3;
  opcode_e       w_opcode;
  instr_format_e w_fmt;
  logic          w_we_allowed;
  logic          w_illegal;
  rd_src_e       w_rd_src;

  assign w_funct3 = i_instr[14:12];
  assign w_opcode = opcode_e'(i_instr[6:2]);

  // Classify opcode into format, rd source, write permission and legality
  always_comb begin
    w_fmt        = INSTR_FORMAT_OTHER;
    w_we_allowed = 1'b1;
    w_illegal    = 1'b1;
    w_rd_src     = RD_SRC_ALU_RESULT;
    if (i_instr[1:0] == 2'b11) begin
      w_illegal = 1'b0;
      case (w_opcode)
        OPCODE_LUI, OPCODE_AUIPC: w_fmt = INSTR_FORMAT_U;
        OPCODE_JAL: begin
          w_fmt    = INSTR_FORMAT_J;
          w_rd_src = RD_SRC_NEXT_SEQ_PC;
        end
        OPCODE_JALR: begin
          w_fmt    = INSTR_FORMAT_I;
          w_rd_src = RD_SRC_NEXT_SEQ_PC;
        end
        OPCODE_LOAD: begin
          w_fmt    = INSTR_FORMAT_I;
          w_rd_src = RD_SRC_MEM_LOAD;
        end
        OPCODE_OP_IMM: w_fmt = INSTR_FORMAT_I;
        OPCODE_MISC_MEM: begin
          w_fmt        = INSTR_FORMAT_I;
          w_we_allowed = 1'b0;
        end
        OPCODE_STORE: begin
          w_fmt        = INSTR_FORMAT_S;
          w_we_allowed = 1'b0;
        end
        OPCODE_BRANCH: begin
          w_fmt        = INSTR_FORMAT_B;
          w_we_allowed = 1'b0;
          w_illegal    = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        end
        OPCODE_OP: w_fmt = INSTR_FORMAT_R;
        OPCODE_SYSTEM: begin
          if ((w_funct3 == FUNCT3_CSRRWI) || (w_funct3 == FUNCT3_CSRRSI) ||
              (w_funct3 == FUNCT3_CSRRCI))
            w_fmt = INSTR_FORMAT_UIMM;
          else
            w_fmt = INSTR_FORMAT_I;
          if (w_funct3 != FUNCT3_ECALL_EBREAK)
            w_rd_src = RD_SRC_CSR;
        end
        default: begin
          w_fmt     = INSTR_FORMAT_OTHER;
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  // Assemble the bundle: immediate unscrambling and operand routing by format
  always_comb begin
    o_dec         = '0;
    o_dec.rd_idx  = i_instr[11:7];
    o_dec.rs1_idx = i_instr[19:15];
    o_dec.rs2_idx = i_instr[24:20];
    o_dec.format  = w_fmt;
    o_dec.rd_src  = w_rd_src;
    o_dec.illegal = w_illegal;
    o_dec.rd_we   = w_we_allowed && !w_illegal && (i_instr[11:7] != 5'd0);
    o_dec.cmp_op  = (w_opcode == OPCODE_BRANCH) ? cmp_op_e'(w_funct3) : CMP_OP_EQ;
    case (w_fmt)
      INSTR_FORMAT_I:    o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
      INSTR_FORMAT_S:    o_dec.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      INSTR_FORMAT_B:    o_dec.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                      i_instr[30:25], i_instr[11:8], 1'b0};
      INSTR_FORMAT_U:    o_dec.imm = {i_instr[31:12], 12'b0};
      INSTR_FORMAT_J:    o_dec.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                      i_instr[20], i_instr[30:21], 1'b0};
      INSTR_FORMAT_UIMM: o_dec.imm = {27'b0, i_instr[19:15]};
      default:           o_dec.imm = 32'b0;
    endcase
    if (w_fmt == INSTR_FORMAT_UIMM)
      o_dec.op1_src = ALU_OP1_SRC_CSR_UIMM;
    else if ((w_fmt != INSTR_FORMAT_OTHER) &&
             ((w_opcode == OPCODE_AUIPC) || (w_opcode == OPCODE_JAL) ||
              (w_opcode == OPCODE_BRANCH)))
      o_dec.op1_src = ALU_OP1_SRC_PC;
    else
      o_dec.op1_src = ALU_OP1_SRC_RS1;
    o_dec.op2_src = ((w_fmt == INSTR_FORMAT_R) || (w_fmt == INSTR_FORMAT_B)) ?
                    ALU_OP2_SRC_RS2 : ALU_OP2_SRC_IMM;
  end

endmodule

// File: rtl/core_decode_stage.sv
// LETC decode stage: decodes on the input path, then holds results in an
// output register backed by a one-entry skid register so that both ready
// signals come straight from flops.
module core_decode_stage
  import core_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_if_valid,
  output logic                o_if_ready,
  input  logic [31:0]         i_if_instr,
  input  logic [PC_WIDTH-1:0] i_if_pc,
  output logic                o_ex_valid,
  input  logic                i_ex_ready,
  output logic [PC_WIDTH-1:0] o_ex_pc,
  output logic [4:0]          o_ex_rd_idx,
  output logic [4:0]          o_ex_rs1_idx,
  output logic [4:0]          o_ex_rs2_idx,
  output logic [31:0]         o_ex_imm,
  output logic [2:0]          o_ex_format,
  output logic [1:0]          o_ex_rd_src,
  output logic [1:0]          o_ex_op1_src,
  output logic [1:0]          o_ex_op2_src,
  output logic [2:0]          o_ex_cmp_op,
  output logic                o_ex_rd_we,
  output logic                o_ex_illegal
);

  decode_out_s        w_dec_p0;
  decode_out_s        r_out_p1;
  decode_out_s        r_skid_p1;
  logic [PC_WIDTH-1:0] r_out_pc_p1;
  logic [PC_WIDTH-1:0] r_skid_pc_p1;

  decode_skid_state_e r_state;
  decode_skid_state_e w_state_next;
  logic               r_ex_valid;
  logic               r_if_ready;
  logic               w_accept;
  logic               w_drain;
  logic               w_load_out;
  logic               w_out_from_skid;
  logic               w_load_skid;

  core_decode_comb u_decode_comb (
    .i_instr (i_if_instr),
    .o_dec   (w_dec_p0)
  );

  assign w_accept = i_if_valid && r_if_ready;
  assign w_drain  = r_ex_valid && i_ex_ready;

  // Skid-buffer occupancy plus registered valid/ready derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SKID_EMPTY;
      r_ex_valid <= 1'b0;
      r_if_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_ex_valid <= (w_state_next != SKID_EMPTY);
      r_if_ready <= (w_state_next != SKID_TWO);
    end
  end

  // Next-state and register load selection; flush overrides everything
  always_comb begin
    w_state_next    = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (i_flush) begin
      w_state_next = SKID_EMPTY;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            w_state_next = SKID_ONE;
            w_load_out   = 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_drain) begin
            w_load_out = 1'b1;
          end else if (w_accept) begin
            w_state_next = SKID_TWO;
            w_load_skid  = 1'b1;
          end else if (w_drain) begin
            w_state_next = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_drain) begin
            w_state_next    = SKID_ONE;
            w_load_out      = 1'b1;
            w_out_from_skid = 1'b1;
          end
        end
        default: w_state_next = SKID_EMPTY;
      endcase
    end
  end

  // Stage boundary p0 -> p1: output and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p1     <= '0;
      r_out_pc_p1  <= '0;
      r_skid_p1    <= '0;
      r_skid_pc_p1 <= '0;
    end else begin
      if (w_load_out) begin
        r_out_p1    <= w_out_from_skid ? r_skid_p1 : w_dec_p0;
        r_out_pc_p1 <= w_out_from_skid ? r_skid_pc_p1 : i_if_pc;
      end
      if (w_load_skid) begin
        r_skid_p1    <= w_dec_p0;
        r_skid_pc_p1 <= i_if_pc;
      end
    end
  end

  assign o_if_ready   = r_if_ready;
  assign o_ex_valid   = r_ex_valid;
  assign o_ex_pc      = r_out_pc_p1;
  assign o_ex_rd_idx  = r_out_p1.rd_idx;
  assign o_ex_rs1_idx = r_out_p1.rs1_idx;
  assign o_ex_rs2_idx = r_out_p1.rs2_idx;
  assign o_ex_imm     = r_out_p1.imm;
  assign o_ex_format  = r_out_p1.format;
  assign o_ex_rd_src  = r_out_p1.rd_src;
  assign o_ex_op1_src = r_out_p1.op1_src;
  assign o_ex_op2_src = r_out_p1.op2_src;
  assign o_ex_cmp_op  = r_out_p1.cmp_op;
  assign o_ex_rd_we   = r_out_p1.rd_we;
  assign o_ex_illegal = r_out_p1.illegal;

endmodule

// File: tb/tb_core_decode_stage.sv
// Directed bench for the LETC decode stage.
module tb_core_decode_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_if_valid = 1'b0;
  logic        o_if_ready;
  logic [31:0] i_if_instr = 32'h0;
  logic [31:0] i_if_pc = 32'h0;
  logic        o_ex_valid;
  logic        i_ex_ready = 1'b0;
  logic [31:0] o_ex_pc;
  logic [4:0]  o_ex_rd_idx, o_ex_rs1_idx, o_ex_rs2_idx;
  logic [31:0] o_ex_imm;
  logic [2:0]  o_ex_format;
  logic [1:0]  o_ex_rd_src, o_ex_op1_src, o_ex_op2_src;
  logic [2:0]  o_ex_cmp_op;
  logic        o_ex_rd_we, o_ex_illegal;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_decode_stage #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
    .i_if_instr(i_if_instr), .i_if_pc(i_if_pc),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_ex_pc(o_ex_pc),
    .o_ex_rd_idx(o_ex_rd_idx), .o_ex_rs1_idx(o_ex_rs1_idx), .o_ex_rs2_idx(o_ex_rs2_idx),
    .o_ex_imm(o_ex_imm), .o_ex_format(o_ex_format), .o_ex_rd_src(o_ex_rd_src),
    .o_ex_op1_src(o_ex_op1_src), .o_ex_op2_src(o_ex_op2_src), .o_ex_cmp_op(o_ex_cmp_op),
    .o_ex_rd_we(o_ex_rd_we), .o_ex_illegal(o_ex_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_if_valid = 1'b0; i_ex_ready = 1'b0; i_flush = 1'b0;
    step(); step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_ex_valid); else n_pass++;
    n_total++; if (o_if_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", o_if_ready); else n_pass++;
    n_total++; if (o_ex_imm !== 32'h0) $display("FAIL rst_imm got %h want 0", o_ex_imm); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_R) $display("FAIL rst_format got %0d want %0d", o_ex_format, INSTR_FORMAT_R); else n_pass++;
    n_total++; if (o_ex_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", o_ex_pc); else n_pass++;
    n_total++; if (o_ex_rd_we !== 1'b0) $display("FAIL rst_rd_we got %b want 0", o_ex_rd_we); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    i_ex_ready = 1'b1; i_if_valid = 1'b1; i_if_instr = 32'hFFF08293; i_if_pc = 32'h100;
    step();
    i_if_valid = 1'b0;
    n_total++; if (o_ex_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", o_ex_valid); else n_pass++;
    n_total++; if (o_ex_pc !== 32'h100) $display("FAIL addi_pc got %h want 100", o_ex_pc); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_I) $display("FAIL addi_format got %0d want %0d", o_ex_format, INSTR_FORMAT_I); else n_pass++;
    n_total++; if (o_ex_imm !== 32'hFFFFFFFF) $display("FAIL addi_imm got %h want ffffffff", o_ex_imm); else n_pass++;
    n_total++; if (o_ex_rd_idx !== 5'd5) $display("FAIL addi_rd got %0d want 5", o_ex_rd_idx); else n_pass++;
    n_total++; if (o_ex_rs1_idx !== 5'd1) $display("FAIL addi_rs1 got %0d want 1", o_ex_rs1_idx); else n_pass++;
    n_total++; if (o_ex_rd_we !== 1'b1) $display("FAIL addi_rd_we got %b want 1", o_ex_rd_we); else n_pass++;
    n_total++; if (o_ex_op2_src !== ALU_OP2_SRC_IMM) $display("FAIL addi_op2 got %0d want %0d", o_ex_op2_src, ALU_OP2_SRC_IMM); else n_pass++;
    n_total++; if (o_ex_rd_src !== RD_SRC_ALU_RESULT) $display("FAIL addi_rd_src got %0d want %0d", o_ex_rd_src, RD_SRC_ALU_RESULT); else n_pass++;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL addi_drained got %b want 0", o_ex_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_instr = 32'hFE000EE3; i_if_pc = 32'h200;
    step();
    n_total++; if (o_if_ready !== 1'b1) $display("FAIL bp_ready_one got %b want 1", o_if_ready); else n_pass++;
    i_if_instr = 32'h123450B7; i_if_pc = 32'h204;
    step();
    i_if_valid = 1'b0;
    n_total++; if (o_if_ready !== 1'b0) $display("FAIL bp_ready_two got %b want 0", o_if_ready); else n_pass++;
    step();
    n_total++; if (o_ex_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", o_ex_valid); else n_pass++;
    n_total++; if (o_ex_pc !== 32'h200) $display("FAIL bp_hold_pc got %h want 200", o_ex_pc); else n_pass++;
    n_total++; if (o_ex_imm !== 32'hFFFFFFFC) $display("FAIL bp_beq_imm got %h want fffffffc", o_ex_imm); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_B) $display("FAIL bp_beq_format got %0d want %0d", o_ex_format, INSTR_FORMAT_B); else n_pass++;
    n_total++; if (o_ex_op1_src !== ALU_OP1_SRC_PC) $display("FAIL bp_beq_op1 got %0d want %0d", o_ex_op1_src, ALU_OP1_SRC_PC); else n_pass++;
    n_total++; if (o_ex_cmp_op !== CMP_OP_EQ) $display("FAIL bp_beq_cmp got %0d want %0d", o_ex_cmp_op, CMP_OP_EQ); else n_pass++;
    n_total++; if (o_ex_rd_we !== 1'b0) $display("FAIL bp_beq_rd_we got %b want 0", o_ex_rd_we); else n_pass++;
    i_ex_ready = 1'b1;
    step();
    n_total++; if (o_ex_valid !== 1'b1) $display("FAIL bp_lui_valid got %b want 1", o_ex_valid); else n_pass++;
    n_total++; if (o_ex_pc !== 32'h204) $display("FAIL bp_lui_pc got %h want 204", o_ex_pc); else n_pass++;
    n_total++; if (o_ex_imm !== 32'h12345000) $display("FAIL bp_lui_imm got %h want 12345000", o_ex_imm); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_U) $display("FAIL bp_lui_format got %0d want %0d", o_ex_format, INSTR_FORMAT_U); else n_pass++;
    n_total++; if (o_ex_rd_idx !== 5'd1) $display("FAIL bp_lui_rd got %0d want 1", o_ex_rd_idx); else n_pass++;
    n_total++; if (o_if_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", o_if_ready); else n_pass++;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", o_ex_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    i_ex_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = {12'(k), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
      i_if_valid = 1'b1; i_if_instr = w; i_if_pc = 32'h300 + 32'(4 * k);
      step();
      n_total++; if (o_ex_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", k, o_ex_valid); else n_pass++;
      n_total++; if (o_ex_pc !== 32'h300 + 32'(4 * k)) $display("FAIL b2b_pc[%0d] got %h want %h", k, o_ex_pc, 32'h300 + 32'(4 * k)); else n_pass++;
      n_total++; if (o_ex_imm !== 32'(k)) $display("FAIL b2b_imm[%0d] got %h want %h", k, o_ex_imm, 32'(k)); else n_pass++;
      n_total++; if (o_ex_rd_idx !== 5'(k + 1)) $display("FAIL b2b_rd[%0d] got %0d want %0d", k, o_ex_rd_idx, k + 1); else n_pass++;
      n_total++; if (o_if_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", k, o_if_ready); else n_pass++;
    end
    i_if_valid = 1'b0;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", o_ex_valid); else n_pass++;
  endtask

  task automatic test_flush();
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_instr = 32'hFFF08293; i_if_pc = 32'h400;
    step();
    i_if_pc = 32'h404;
    step();
    n_total++; if (o_if_ready !== 1'b0) $display("FAIL fl_two_ready got %b want 0", o_if_ready); else n_pass++;
    i_flush = 1'b1; i_if_pc = 32'h408;
    step();
    i_flush = 1'b0; i_if_valid = 1'b0; i_ex_ready = 1'b1;
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL fl_two_valid got %b want 0", o_ex_valid); else n_pass++;
    n_total++; if (o_if_ready !== 1'b1) $display("FAIL fl_two_ready_after got %b want 1", o_if_ready); else n_pass++;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL fl_two_stays_empty got %b want 0", o_ex_valid); else n_pass++;
    // flush in ONE with an input transfer offered on the same edge
    i_ex_ready = 1'b0; i_if_valid = 1'b1; i_if_pc = 32'h500;
    step();
    i_flush = 1'b1; i_if_pc = 32'h504;
    step();
    i_flush = 1'b0; i_if_valid = 1'b0;
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL fl_one_valid got %b want 0", o_ex_valid); else n_pass++;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL fl_one_dropped got %b want 0", o_ex_valid); else n_pass++;
    i_ex_ready = 1'b1;
  endtask

  task automatic test_illegal_csr();
    i_ex_ready = 1'b1;
    i_if_valid = 1'b1; i_if_instr = 32'h00000000; i_if_pc = 32'h600;
    step();
    n_total++; if (o_ex_illegal !== 1'b1) $display("FAIL ill0_illegal got %b want 1", o_ex_illegal); else n_pass++;
    n_total++; if (o_ex_rd_we !== 1'b0) $display("FAIL ill0_rd_we got %b want 0", o_ex_rd_we); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_OTHER) $display("FAIL ill0_format got %0d want %0d", o_ex_format, INSTR_FORMAT_OTHER); else n_pass++;
    i_if_instr = 32'h0000007F;
    step();
    n_total++; if (o_ex_illegal !== 1'b1) $display("FAIL ill7f_illegal got %b want 1", o_ex_illegal); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_OTHER) $display("FAIL ill7f_format got %0d want %0d", o_ex_format, INSTR_FORMAT_OTHER); else n_pass++;
    i_if_instr = 32'h3002D1F3;
    step();
    n_total++; if (o_ex_format !== INSTR_FORMAT_UIMM) $display("FAIL csr_format got %0d want %0d", o_ex_format, INSTR_FORMAT_UIMM); else n_pass++;
    n_total++; if (o_ex_imm !== 32'd5) $display("FAIL csr_imm got %h want 5", o_ex_imm); else n_pass++;
    n_total++; if (o_ex_rd_src !== RD_SRC_CSR) $display("FAIL csr_rd_src got %0d want %0d", o_ex_rd_src, RD_SRC_CSR); else n_pass++;
    n_total++; if (o_ex_op1_src !== ALU_OP1_SRC_CSR_UIMM) $display("FAIL csr_op1 got %0d want %0d", o_ex_op1_src, ALU_OP1_SRC_CSR_UIMM); else n_pass++;
    n_total++; if (o_ex_rd_idx !== 5'd3) $display("FAIL csr_rd got %0d want 3", o_ex_rd_idx); else n_pass++;
    n_total++; if (o_ex_illegal !== 1'b0) $display("FAIL csr_illegal got %b want 0", o_ex_illegal); else n_pass++;
    i_if_instr = 32'h00208033;
    step();
    i_if_valid = 1'b0;
    n_total++; if (o_ex_rd_we !== 1'b0) $display("FAIL add_x0_rd_we got %b want 0", o_ex_rd_we); else n_pass++;
    n_total++; if (o_ex_format !== INSTR_FORMAT_R) $display("FAIL add_format got %0d want %0d", o_ex_format, INSTR_FORMAT_R); else n_pass++;
    n_total++; if (o_ex_op2_src !== ALU_OP2_SRC_RS2) $display("FAIL add_op2 got %0d want %0d", o_ex_op2_src, ALU_OP2_SRC_RS2); else n_pass++;
    n_total++; if (o_ex_rs2_idx !== 5'd2) $display("FAIL add_rs2 got %0d want 2", o_ex_rs2_idx); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_instr = 32'hFFF08293; i_if_pc = 32'h700;
    step();
    n_total++; if (o_ex_valid !== 1'b1) $display("FAIL rm_pre_valid got %b want 1", o_ex_valid); else n_pass++;
    rst = 1'b1; i_if_pc = 32'h704;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", o_ex_valid); else n_pass++;
    n_total++; if (o_if_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", o_if_ready); else n_pass++;
    n_total++; if (o_ex_pc !== 32'h0) $display("FAIL rm_pc got %h want 0", o_ex_pc); else n_pass++;
    rst = 1'b0; i_if_valid = 1'b0; i_ex_ready = 1'b1;
    step();
    n_total++; if (o_ex_valid !== 1'b0) $display("FAIL rm_after got %b want 0", o_ex_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_illegal_csr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
